timer_counter: RTL
==================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of count, data and terminal compare.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 r  input  1  reset, synchronous, active-high.
REQ-004 e  input  1  count enable; count advances only in cycles with e=1.
REQ-005 start  input  1  single-cycle request to begin (or restart) a count run.
REQ-006 stop  input  1  single-cycle request to abort a run; count is held.
REQ-007 mode  input  2  bit0 = direction (0 up, 1 down); bit1 = one-shot (1) / periodic (0).
REQ-008 data  input  WIDTH  terminal value; sampled into term_q on accepted start.
REQ-009 count  output  WIDTH  current count, registered.
REQ-010 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  high while in DONE (one-shot finished).

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: count held; start -> RUN, load count (0 if up, data if down), latch mode_q <= mode and term_q <= data.
REQ-015 RUN, e=1, up: if count==term_q then the terminal event occurs, else count+1.
REQ-016 RUN, e=1, down: if count==0 then the terminal event occurs, else count-1.
REQ-017 Terminal event, periodic: count reloads (0 up / term_q down), state stays RUN, tc=1 next cycle.
REQ-018 Terminal event, one-shot: count holds the terminal value, state -> DONE, tc=1 next cycle.
REQ-019 RUN, e=0: count, state and mode_q held; tc=0.
REQ-020 tc SHALL be high exactly one cycle per terminal event and coincide with the reloaded/held count.
REQ-021 term_q=0 with e=1: every enabled cycle is a terminal event; count stays 0; tc high every enabled cycle.
REQ-022 mode and data changes during RUN SHALL be ignored until the next accepted start.
REQ-023 stop in RUN -> IDLE, count held, tc=0; stop in IDLE/DONE has no effect.
REQ-024 start and stop in the same cycle: stop wins; start is ignored.
REQ-025 start in RUN SHALL restart: reload count, re-latch mode_q/term_q, stay RUN, no tc.
REQ-026 start in DONE -> RUN with reload as in REQ-014.
REQ-027 All arithmetic modulo 2^WIDTH; no carry output; count never exceeds term_q in up mode once started.
REQ-028 busy = (state==RUN), done = (state==DONE), both registered-state decodes, glitch-free.

Reset
REQ-029 r=1 at a clock edge SHALL force state=IDLE, count=0, tc=0, term_q=0, mode_q=0, overriding all other inputs.
REQ-030 Reset mid-run SHALL drop any pending tc; first count activity requires a fresh start after r=0.

Structure
REQ-031 FSM state encodings and mode bit positions SHALL live in the shared package timer_counter_pkg.
REQ-032 Single module, no sub-module; one sequential block plus next-state/next-count logic.
REQ-033 No latches; all outputs driven from flops or decodes of flops.

Verification (WIDTH=4)
REQ-034 Periodic up, data=5, e=1 constant: count 0..5,0..; tc high when count returns to 0, every 6 cycles.
REQ-035 One-shot down, data=3: count 3,2,1,0 then held 0; tc one cycle; done=1, busy=0; further e ignored.
REQ-036 Periodic up, data=15: count wraps 15->0 with tc; e toggled 1/0 -> count stalls on e=0 cycles, no tc.
REQ-037 start+stop same cycle in IDLE -> stays IDLE; stop at count=4 in RUN -> IDLE, count=4 held.
REQ-038 data=0 periodic up, e=1 -> count=0 constant, tc high every cycle; data changed to 9 mid-run -> no effect.
REQ-039 r=1 at count=7 in RUN with terminal due next cycle -> IDLE, count=0, tc=0, no late tc pulse.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter block: FSM state encoding and the
// bit positions inside the two-bit mode field.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // mode[MODE_DIR] selects down counting, mode[MODE_ONESHOT] selects one-shot
  localparam int MODE_DIR     = 0;
  localparam int MODE_ONESHOT = 1;

endpackage

// File: rtl/timer_counter.sv
// Up/down timer with periodic or one-shot runs, start/stop/restart control and
// a one-cycle registered terminal-count pulse aligned with the reloaded count.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             e,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             accept_start;
  logic             terminal;

  // stop always dominates a simultaneous start
  assign accept_start = start && !stop;
  assign terminal     = mode_q[MODE_DIR] ? (count == '0) : (count == term_q);

  always_comb begin
    state_d = state_q;
    count_d = count;
    term_d  = term_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_start) begin
          state_d = ST_RUN;
          count_d = mode[MODE_DIR] ? data : '0;
          term_d  = data;
          mode_d  = mode;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          count_d = mode[MODE_DIR] ? data : '0;
          term_d  = data;
          mode_d  = mode;
        end else if (e) begin
          if (terminal) begin
            tc_d = 1'b1;
            // one-shot holds the terminal value; periodic reloads
            if (mode_q[MODE_ONESHOT]) begin
              state_d = ST_DONE;
            end else begin
              count_d = mode_q[MODE_DIR] ? term_q : '0;
            end
          end else begin
            count_d = mode_q[MODE_DIR] ? (count - WIDTH'(1)) : (count + WIDTH'(1));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= ST_IDLE;
      count   <= '0;
      tc      <= 1'b0;
      term_q  <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      tc      <= tc_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
